// File: rtl/debounce_pkg.sv
// Shared types for the switch debouncer: per-channel filter states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package debounce_pkg;

    // Stable-low, confirming-high, stable-high, confirming-low.
    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } deb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch: synchroniser, 4-state filter FSM, registered level and edge pulses.
// Latency: SYNC_STAGES cycles of sync plus N_SAMPLES stable ticks (first tick may be partial).
// Backpressure: none; any bounce during confirmation restarts the filter.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int N_SAMPLES   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    input  logic tick,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(N_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_SAMPLES - 1);
    // Reset value of the synchroniser chosen so the filtered input reads 0.
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, fall_q;

    // Shift the raw switch through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync_q <= {SYNC_STAGES{POL}};
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
    end

    assign s = sync_q[SYNC_STAGES-1] ^ POL;

    // Filter state, sample counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= db_d & ~db_q;
            fall_q  <= ~db_d & db_q;
        end
    end

    // Next state: a bounce always wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ZERO: begin
                if (s) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ONE: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (s) begin
                    state_d = ONE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ZERO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
    end

    // Debounced level follows the next state so db and the state register move together.
    always_comb begin
        db_d = (state_d == ONE) || (state_d == WAIT0);
    end

    assign db   = db_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/mod_m_count.sv
// Free-running modulo-M counter; max_tick marks the last count before wrap.
// Latency: max_tick high for one cycle every M cycles, decoded from the count register.
// Backpressure: none, free-running.
module mod_m_count #(
    parameter int M = 10
) (
    input  logic clk,
    input  logic reset,
    output logic max_tick
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    logic [CW-1:0] count_q;

    // Count 0..M-1 and wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else if (count_q == LAST)
            count_q <= '0;
        else
            count_q <= count_q + CW'(1);
    end

    assign max_tick = (count_q == LAST);

endmodule

// File: rtl/multi_debouncer.sv
// N-channel switch debouncer with a shared sample tick and per-channel rise/fall pulses.
// Latency: SYNC_STAGES + between (N_SAMPLES-1)*TICK_M+1 and N_SAMPLES*TICK_M+1 cycles.
// Backpressure: none; channels are independent and always accept input.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TICK_M      = 500_000,
    parameter int N_SAMPLES   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    logic tick;

    mod_m_count #(
        .M (TICK_M)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .max_tick (tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .N_SAMPLES   (N_SAMPLES),
            .SYNC_STAGES (SYNC_STAGES),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .sw    (sw[i]),
            .tick  (tick),
            .db    (db[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: two channels, 10-cycle tick, 3 samples.
// Latency: n/a.
// Backpressure: n/a.
module tb_multi_debouncer;
    import debounce_pkg::*;

    logic       clk;
    logic       reset;
    logic [1:0] sw;
    logic [1:0] db, rise, fall;

    multi_debouncer #(
        .N_CH        (2),
        .TICK_M      (10),
        .N_SAMPLES   (3),
        .SYNC_STAGES (2),
        .ACTIVE_LOW  (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .db    (db),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;
    int rise_cyc [2];
    int fall_cyc [2];
    int both_cnt = 0;

    // Cycle index since last reset release; cycle k is seen at the negedge after edge k.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Pulse monitors: cycles each pulse is high, and rise/fall coincidence.
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                if (rise[c]) rise_cyc[c] = rise_cyc[c] + 1;
                if (fall[c]) fall_cyc[c] = fall_cyc[c] + 1;
            end
            if ((rise & fall) != 2'b00) both_cnt = both_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for db[ch] to reach val; lat is the number of cycles waited.
    task automatic wait_db(input int ch, input logic val, input int max_cyc, output int lat);
        lat = 0;
        while (db[ch] !== val && lat < max_cyc) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        int         at;
        logic [1:0] sw_v;
        logic [1:0] db_e;
        logic [1:0] rise_e;
        logic [1:0] fall_e;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat;
        int found;

        for (int c = 0; c < 2; c++) begin
            rise_cyc[c] = 0;
            fall_cyc[c] = 0;
        end

        // Press at cycle 3 lands in cycle 30; release at cycle 50 lands in cycle 80.
        vecs[0] = '{0,  2'b00, 2'b00, 2'b00, 2'b00};
        vecs[1] = '{3,  2'b01, 2'b00, 2'b00, 2'b00};
        vecs[2] = '{20, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[3] = '{28, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[4] = '{32, 2'b01, 2'b01, 2'b00, 2'b00};
        vecs[5] = '{50, 2'b00, 2'b01, 2'b00, 2'b00};
        vecs[6] = '{70, 2'b00, 2'b01, 2'b00, 2'b00};
        vecs[7] = '{82, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[8] = '{90, 2'b00, 2'b00, 2'b00, 2'b00};

        reset = 1'b1;
        sw    = 2'b00;
        step(2);
        #2 check("reset_db", {30'd0, db}, 32'd0);
        check("reset_rise", {30'd0, rise}, 32'd0);
        check("reset_fall", {30'd0, fall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Clean press and release, table driven.
        for (int i = 0; i < 9; i++) begin
            while (cyc < vecs[i].at) @(negedge clk);
            sw = vecs[i].sw_v;
            check($sformatf("vec%0d_db", i),   {30'd0, db},   {30'd0, vecs[i].db_e});
            check($sformatf("vec%0d_rise", i), {30'd0, rise}, {30'd0, vecs[i].rise_e});
            check($sformatf("vec%0d_fall", i), {30'd0, fall}, {30'd0, vecs[i].fall_e});
        end
        check("press_rise_pulses", rise_cyc[0], 1);
        check("release_fall_pulses", fall_cyc[0], 1);
        check("ch1_quiet", rise_cyc[1] + fall_cyc[1], 0);

        // Short glitch: 12 cycles high never reaches three ticks.
        sw[0] = 1'b1;
        step(12);
        sw[0] = 1'b0;
        step(40);
        check("glitch_db", {31'd0, db[0]}, 32'd0);
        check("glitch_rise", rise_cyc[0], 1);
        check("glitch_state", {30'd0, dut.g_ch[0].u_ch.state_q}, {30'd0, ZERO});

        // Rapid bounce, then hold high.
        for (int i = 0; i < 60; i++) begin
            sw[0] = ~sw[0];
            step(3);
        end
        check("bounce_no_rise", rise_cyc[0], 1);
        check("bounce_db", {31'd0, db[0]}, 32'd0);
        sw[0] = 1'b1;
        wait_db(0, 1'b1, 40, lat);
        check("bounce_settle_db", {31'd0, db[0]}, 32'd1);
        check("bounce_settle_lat", {31'd0, (lat >= 21 && lat <= 34)}, 32'd1);
        step(2);
        check("bounce_rise_pulses", rise_cyc[0], 2);

        // Channel 1 bounces while channel 0 holds high.
        for (int i = 0; i < 25; i++) begin
            sw[1] = ~sw[1];
            step(4);
        end
        sw[1] = 1'b0;
        step(10);
        check("indep_db", {30'd0, db}, 32'd1);
        check("indep_fall0", fall_cyc[0], 1);
        check("indep_rise1", rise_cyc[1], 0);
        sw[1] = 1'b1;
        wait_db(1, 1'b1, 40, lat);
        check("ch1_press_lat", {31'd0, (lat >= 21 && lat <= 34)}, 32'd1);
        check("ch1_press_db", {30'd0, db}, 32'd3);
        sw[1] = 1'b0;
        wait_db(1, 1'b0, 40, lat);
        step(2);
        check("ch1_release_db", {30'd0, db}, 32'd1);
        check("ch1_pulses", rise_cyc[1] * 10 + fall_cyc[1], 11);

        // Reset while db[0]=1: clears at once, no fall pulse.
        #2 reset = 1'b1;
        #1 check("rst_hi_db", {30'd0, db}, 32'd0);
        check("rst_hi_fall", {30'd0, fall}, 32'd0);
        step(3);
        reset = 1'b0;
        check("rst_hi_fall_cnt", fall_cyc[0], 1);

        // Reset in WAIT1 with cnt=1, then a full three-tick confirmation.
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (dut.g_ch[0].u_ch.state_q == WAIT1 && dut.g_ch[0].u_ch.cnt_q == 2'd1)
                found = 1;
            else
                @(negedge clk);
        end
        check("wait1_cnt1_reached", found, 1);
        #2 reset = 1'b1;
        #1 check("rst_w1_db", {30'd0, db}, 32'd0);
        check("rst_w1_rise", {30'd0, rise}, 32'd0);
        check("rst_w1_fall", {30'd0, fall}, 32'd0);
        check("rst_w1_state", {30'd0, dut.g_ch[0].u_ch.state_q}, {30'd0, ZERO});
        @(negedge clk);
        reset = 1'b0;
        wait_db(0, 1'b1, 40, lat);
        check("rst_full_count_lat", {31'd0, (lat >= 28 && lat <= 32)}, 32'd1);
        step(2);
        check("rst_rise_pulses", rise_cyc[0], 3);
        check("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required to finish");
        $fatal(1);
    end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
Parametrised N-channel switch debouncer for push-buttons and slide switches on the 50 MHz board clock. Each channel is synchronised and filtered by its own small state machine. A channel's output changes only after the input holds a new level for N_SAMPLES consecutive ticks of one shared tick generator. The block also gives one-cycle rise/fall pulses per channel, so downstream FSMs need no separate edge detectors.

Parameters:
N_CH, 4, number of independent input channels
TICK_M, 500_000, clk cycles per sample tick (10 ms at 50 MHz); must be >= 2
N_SAMPLES, 3, consecutive ticks of stable level needed to change db; must be >= 1
SYNC_STAGES, 2, flip-flops in each input synchroniser; must be >= 2
ACTIVE_LOW, 0, 1 = invert sw after synchronisation (pull-up buttons)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sw  in  N_CH  raw asynchronous switch inputs
db  out  N_CH  debounced level, registered
rise  out  N_CH  one-cycle pulse when db[i] goes 0->1
fall  out  N_CH  one-cycle pulse when db[i] goes 1->0

Behaviour:
- Reset: all synchroniser flops cleared, or set when ACTIVE_LOW=1 so s_i reads 0. Tick counter = 0; every channel in ZERO; db = 0, rise = 0, fall = 0.
- Synchroniser: SYNC_STAGES-deep chain per bit. s_i is the last stage, XOR ACTIVE_LOW.
- Tick: free-running counter 0..TICK_M-1, wraps to 0. tick = 1 for the single cycle where count == TICK_M-1. It is shared by all channels.
- Per-channel FSM states: ZERO, WAIT1, ONE, WAIT0. Each channel has its own sample counter cnt, width $clog2(N_SAMPLES+1).
- ZERO: if s_i, go to WAIT1 and set cnt = 0; otherwise stay.
- WAIT1: if !s_i, go to ZERO and set cnt = 0. Else, on tick, cnt++; when cnt reaches N_SAMPLES-1 on a tick, go to ONE.
- ONE and WAIT0: the mirror of ZERO and WAIT1 with s_i inverted. WAIT0 reaches ZERO after N_SAMPLES stable-low ticks.
- Bounce and tick on the same cycle in WAIT1/WAIT0: the bounce wins; return to the stable state with cnt = 0.
- Illegal state encodings go to ZERO through the default arm. No state may hold forever under any input sequence.
- db_i = 1 in ONE and WAIT0, 0 in ZERO and WAIT1. It is driven from a register, with no combinational path from sw.
- rise_i / fall_i: registered, high for exactly the one cycle in which db_i changes. They are never both high.
- Filter delay: from a stable s_i level to the db change is between (N_SAMPLES-1)*TICK_M+1 and N_SAMPLES*TICK_M+1 cycles. Add SYNC_STAGES cycles from sw.
- Channels are fully independent; activity on one never affects another.
- Reset asserted mid-operation: outputs clear asynchronously, with no rise/fall pulse generated. After release, a high input needs the full N_SAMPLES tick count again.

Decomposition:
- Package debounce_pkg: the deb_state_t enum {ZERO, WAIT1, ONE, WAIT0}.
- Sub-module debounce_channel: one FSM, its cnt, db/rise/fall registers and synchroniser, parametrised by N_SAMPLES, SYNC_STAGES and ACTIVE_LOW.
- Top level: the shared tick counter (existing mod_m_count with M=TICK_M) plus a generate loop of N_CH debounce_channel instances.

Test Plan:
(All scenarios use N_CH=2, TICK_M=10, N_SAMPLES=3, SYNC_STAGES=2, ACTIVE_LOW=0; reset released at cycle 0; ticks at cycles 9, 19, 29, ...)
- Clean press: sw[0]=1 from cycle 3 and held -> db[0]=1 from cycle 30 (±1); rise[0] high for that one cycle only; db[1], rise[1] and fall[1] stay 0.
- Short glitch: sw[0] high for 12 cycles, then 0 -> db[0] stays 0; rise[0] never asserts; FSM back in ZERO.
- Rapid bounce: sw[0] toggles every 3 cycles for 60 toggles, then holds 1 -> db[0] stays 0 during toggling; it goes 1 within 31 cycles of the final edge plus sync delay, with one rise pulse. Checks the FSM is never stuck.
- Release: after db[0]=1, drive sw[0]=0 and hold -> db[0] falls after 21-31 cycles; fall[0] is a single-cycle pulse; rise[0] stays 0.
- Independence and reset: sw[1] bounces while sw[0] is held high -> db[0] is unaffected. Assert reset while channel 0 is in WAIT1 (cnt=1) -> db, rise and fall are 0 at once; after release, db[0] needs the full 3 ticks again.
